// File: rtl/fm_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fm_mod_pkg
// Brief   : Shared constants, FSM state type and CORDIC arctangent table
//           for the FM modulator.
// Revision: 1.0 - initial release
// ============================================================================
package fm_mod_pkg;

  localparam int PI              = 3217;
  localparam int HALF_PI         = 1608;
  localparam int TWO_PI          = 6434;
  localparam int CORDIC_GAIN_Q10 = 622;
  localparam int DELTA_MAX       = PI - 1;

  typedef enum logic [1:0] {
    ST_READ   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  // atan(2^-k) in Q10 radians
  function automatic int atan_q10(input logic [3:0] k);
    int v;
    case (k)
      4'd0:    v = 804;
      4'd1:    v = 475;
      4'd2:    v = 251;
      4'd3:    v = 127;
      4'd4:    v = 64;
      4'd5:    v = 32;
      4'd6:    v = 16;
      4'd7:    v = 8;
      4'd8:    v = 4;
      4'd9:    v = 2;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fm_mod_if.sv
`default_nettype none
// ============================================================================
// Module  : fm_mod_if
// Brief   : Audio-in and I/Q-out FIFO handshake bundle of the FM modulator.
// Revision: 1.0 - initial release
// ============================================================================
interface fm_mod_if #(
  parameter int DATA_WIDTH = 32
);

  logic signed [DATA_WIDTH-1:0] audio;
  logic                         empty_audio;
  logic                         rd_en_audio;
  logic signed [DATA_WIDTH-1:0] rl_out;
  logic signed [DATA_WIDTH-1:0] img_out;
  logic                         full_rl;
  logic                         full_img;
  logic                         wr_en_rl;
  logic                         wr_en_img;

  modport master (
    input  audio, empty_audio, full_rl, full_img,
    output rd_en_audio, rl_out, img_out, wr_en_rl, wr_en_img
  );

  modport slave (
    output audio, empty_audio, full_rl, full_img,
    input  rd_en_audio, rl_out, img_out, wr_en_rl, wr_en_img
  );

endinterface
`default_nettype wire

// File: rtl/fm_mod_cordic_rot.sv
`default_nettype none
// ============================================================================
// Module  : cordic_rot
// Brief   : Iterative rotation-mode CORDIC, one micro-rotation per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module cordic_rot
  import fm_mod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] angle,
  input  logic signed [DATA_WIDTH-1:0] x0,
  input  logic signed [DATA_WIDTH-1:0] y0,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic                         done
);

  localparam logic [3:0] c_k_last = 4'(ITER - 1);

  logic signed [DATA_WIDTH-1:0] r_x, r_y, r_z;
  logic signed [DATA_WIDTH-1:0] w_x_sh, w_y_sh, w_atan;
  logic [3:0]                   r_k;
  logic                         r_busy;
  logic                         r_done;

  always_comb begin
    w_x_sh = r_x >>> r_k;
    w_y_sh = r_y >>> r_k;
    w_atan = DATA_WIDTH'(atan_q10(r_k));
  end

  // A start seen while busy falls into the busy branch and is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_k    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (!r_z[DATA_WIDTH-1]) begin
          r_x <= r_x - w_y_sh;
          r_y <= r_y + w_x_sh;
          r_z <= r_z - w_atan;
        end else begin
          r_x <= r_x + w_y_sh;
          r_y <= r_y - w_x_sh;
          r_z <= r_z + w_atan;
        end
        if (r_k == c_k_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_k <= r_k + 4'd1;
        end
      end else if (start) begin
        r_x    <= x0;
        r_y    <= y0;
        r_z    <= angle;
        r_k    <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign cos_out = r_x;
  assign sin_out = r_y;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: rtl/fm_mod.sv
`default_nettype none
// ============================================================================
// Module  : fm_mod
// Brief   : FM modulator - integrates audio into phase, emits I/Q via CORDIC.
// Revision: 1.0 - initial release
// ============================================================================
module fm_mod
  import fm_mod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KF         = 1024,
  parameter int AMP        = 1024,
  parameter int ITER       = 10
) (
  input  logic clk,
  input  logic rst,
  fm_mod_if.master bus
);

  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic signed [W2-1:0]         c_kf        = W2'(KF);
  localparam logic signed [W2-1:0]         c_dmax      = W2'(DELTA_MAX);
  localparam logic signed [W2-1:0]         c_dmin      = -c_dmax;
  localparam logic signed [DATA_WIDTH-1:0] c_pi        = DATA_WIDTH'(PI);
  localparam logic signed [DATA_WIDTH-1:0] c_neg_pi    = -c_pi;
  localparam logic signed [DATA_WIDTH-1:0] c_two_pi    = DATA_WIDTH'(TWO_PI);
  localparam logic signed [DATA_WIDTH-1:0] c_half_pi   = DATA_WIDTH'(HALF_PI);
  localparam logic signed [DATA_WIDTH-1:0] c_neg_half  = -c_half_pi;
  localparam logic signed [DATA_WIDTH-1:0] c_x0        = DATA_WIDTH'((AMP * CORDIC_GAIN_Q10) >>> 10);

  state_t                       r_state, w_state_nxt;
  logic signed [DATA_WIDTH-1:0] r_phase;
  logic signed [DATA_WIDTH-1:0] r_rl, r_img;
  logic                         r_start;

  logic signed [W2-1:0]         w_prod, w_delta_wide;
  logic signed [DATA_WIDTH-1:0] w_delta, w_sum, w_phase_nxt;
  logic signed [DATA_WIDTH-1:0] w_angle;
  logic                         w_neg;
  logic signed [DATA_WIDTH-1:0] w_cos, w_sin;
  logic                         w_done;
  logic                         w_rd_en, w_wr_en;

  // Phase update: saturated step, then wrap into [-PI, PI)
  always_comb begin
    w_prod       = c_kf * W2'(bus.audio);
    w_delta_wide = w_prod >>> 10;
    if (w_delta_wide > c_dmax) begin
      w_delta = DATA_WIDTH'(c_dmax);
    end else if (w_delta_wide < c_dmin) begin
      w_delta = DATA_WIDTH'(c_dmin);
    end else begin
      w_delta = w_delta_wide[DATA_WIDTH-1:0];
    end
    w_sum = r_phase + w_delta;
    if (w_sum >= c_pi) begin
      w_phase_nxt = w_sum - c_two_pi;
    end else if (w_sum < c_neg_pi) begin
      w_phase_nxt = w_sum + c_two_pi;
    end else begin
      w_phase_nxt = w_sum;
    end
  end

  // Fold into the CORDIC convergence range; a half-turn fold flips the result sign
  always_comb begin
    w_angle = r_phase;
    w_neg   = 1'b0;
    if (r_phase > c_half_pi) begin
      w_angle = r_phase - c_pi;
      w_neg   = 1'b1;
    end else if (r_phase < c_neg_half) begin
      w_angle = r_phase + c_pi;
      w_neg   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_READ: begin
        if (!bus.empty_audio && !rst) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        if (w_done) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus.full_rl && !bus.full_img && !rst) begin
          w_wr_en     = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      default: w_state_nxt = ST_READ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_READ;
      r_phase <= '0;
      r_start <= 1'b0;
      r_rl    <= '0;
      r_img   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_rd_en;
      if (w_rd_en) begin
        r_phase <= w_phase_nxt;
      end
      if (r_state == ST_ROTATE && w_done) begin
        r_rl  <= w_neg ? -w_cos : w_cos;
        r_img <= w_neg ? -w_sin : w_sin;
      end
    end
  end

  cordic_rot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ITER       (ITER)
  ) u_cordic (
    .clk     (clk),
    .rst     (rst),
    .start   (r_start),
    .angle   (w_angle),
    .x0      (c_x0),
    .y0      ('0),
    .cos_out (w_cos),
    .sin_out (w_sin),
    .done    (w_done)
  );

  assign bus.rd_en_audio = w_rd_en;
  assign bus.wr_en_rl    = w_wr_en;
  assign bus.wr_en_img   = w_wr_en;
  assign bus.rl_out      = r_rl;
  assign bus.img_out     = r_img;

endmodule
`default_nettype wire
